// File: rtl/lock_entry_sequencer.sv
// Code-entry sequencer for the six-digit lock: packs keypad digits into pairs for the
// entered-code register, triggers the compare and times the unlock, error and lockout phases.
module lock_entry_sequencer #(
    parameter int JUDGE_LAT   = 1,
    parameter int TIMEOUT_CYC = 1000,
    parameter int UNLOCK_CYC  = 500,
    parameter int LOCKOUT_CYC = 2000,
    parameter int MAX_ERR     = 3
) (
    input  logic       true_clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_enter,
    input  logic       key_cancel,
    input  logic       match_in,
    output logic       pair_wr,
    output logic [1:0] pair_sel,
    output logic [7:0] pair_data,
    output logic       entry_clr,
    output logic       judge_en,
    output logic       unlock,
    output logic       lockout,
    output logic [1:0] err_cnt,
    output logic [2:0] digit_cnt,
    output logic       busy
);

    localparam int MAX_AB = (JUDGE_LAT > TIMEOUT_CYC) ? JUDGE_LAT : TIMEOUT_CYC;
    localparam int MAX_CD = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] JUDGE_LOAD   = CW'(JUDGE_LAT - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] UNLOCK_LOAD  = CW'(UNLOCK_CYC - 1);
    localparam logic [CW-1:0] LOCKOUT_LOAD = CW'(LOCKOUT_CYC - 1);
    localparam logic [1:0]    MAX_ERR_W    = 2'(MAX_ERR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_JUDGE,
        S_WAIT,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [3:0]    pending_q, pending_d;
    logic [2:0]    digit_cnt_q, digit_cnt_d;
    logic [1:0]    err_cnt_q, err_cnt_d;
    logic          pair_wr_q, pair_wr_d;
    logic [1:0]    pair_sel_q, pair_sel_d;
    logic [7:0]    pair_data_q, pair_data_d;
    logic          entry_clr_q, entry_clr_d;
    logic          judge_en_q, judge_en_d;
    logic          unlock_q, unlock_d;
    logic          lockout_q, lockout_d;
    logic          busy_q, busy_d;

    logic          digit_ok;
    logic          fail;
    logic [1:0]    err_inc;

    assign digit_ok = key_valid && (key_digit <= 4'd9);
    assign err_inc  = (err_cnt_q == 2'd3) ? 2'd3 : err_cnt_q + 2'd1;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        digit_cnt_d = digit_cnt_q;
        err_cnt_d   = err_cnt_q;
        pair_wr_d   = 1'b0;
        pair_sel_d  = 2'd0;
        pair_data_d = 8'd0;
        entry_clr_d = 1'b0;
        judge_en_d  = 1'b0;
        unlock_d    = 1'b0;
        lockout_d   = 1'b0;
        fail        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (digit_ok) begin
                    pending_d   = key_digit;
                    digit_cnt_d = 3'd1;
                    timer_d     = TIMEOUT_LOAD;
                    state_d     = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (key_cancel) begin
                    entry_clr_d = 1'b1;
                    digit_cnt_d = 3'd0;
                    state_d     = S_IDLE;
                end else if (key_enter) begin
                    if (digit_cnt_q == 3'd6) begin
                        judge_en_d = 1'b1;
                        state_d    = S_JUDGE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (digit_ok && (digit_cnt_q != 3'd6)) begin
                    timer_d     = TIMEOUT_LOAD;
                    digit_cnt_d = digit_cnt_q + 3'd1;
                    // An even count before the new digit means the new one opens a pair.
                    if (!digit_cnt_q[0]) begin
                        pending_d = key_digit;
                    end else begin
                        pair_wr_d   = 1'b1;
                        pair_sel_d  = digit_cnt_q[2:1];
                        pair_data_d = {pending_q, key_digit};
                    end
                end else if (timer_q == '0) begin
                    entry_clr_d = 1'b1;
                    digit_cnt_d = 3'd0;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end

            S_JUDGE: begin
                timer_d = JUDGE_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (timer_q == '0) begin
                    if (match_in) begin
                        err_cnt_d = 2'd0;
                        unlock_d  = 1'b1;
                        timer_d   = UNLOCK_LOAD;
                        state_d   = S_UNLOCKED;
                    end else begin
                        fail = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end

            S_UNLOCKED: begin
                if (timer_q == '0) begin
                    entry_clr_d = 1'b1;
                    digit_cnt_d = 3'd0;
                    state_d     = S_IDLE;
                end else begin
                    unlock_d = 1'b1;
                    timer_d  = timer_q - CW'(1);
                end
            end

            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    err_cnt_d = 2'd0;
                    state_d   = S_IDLE;
                end else begin
                    lockout_d = 1'b1;
                    timer_d   = timer_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Shared failure path for a short entry and a failed compare.
        if (fail) begin
            err_cnt_d   = err_inc;
            entry_clr_d = 1'b1;
            digit_cnt_d = 3'd0;
            if (err_inc >= MAX_ERR_W) begin
                lockout_d = 1'b1;
                timer_d   = LOCKOUT_LOAD;
                state_d   = S_LOCKOUT;
            end else begin
                state_d = S_IDLE;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge true_clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            pending_q   <= 4'd0;
            digit_cnt_q <= 3'd0;
            err_cnt_q   <= 2'd0;
            pair_wr_q   <= 1'b0;
            pair_sel_q  <= 2'd0;
            pair_data_q <= 8'd0;
            entry_clr_q <= 1'b0;
            judge_en_q  <= 1'b0;
            unlock_q    <= 1'b0;
            lockout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            digit_cnt_q <= digit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pair_wr_q   <= pair_wr_d;
            pair_sel_q  <= pair_sel_d;
            pair_data_q <= pair_data_d;
            entry_clr_q <= entry_clr_d;
            judge_en_q  <= judge_en_d;
            unlock_q    <= unlock_d;
            lockout_q   <= lockout_d;
            busy_q      <= busy_d;
        end
    end

    assign pair_wr   = pair_wr_q;
    assign pair_sel  = pair_sel_q;
    assign pair_data = pair_data_q;
    assign entry_clr = entry_clr_q;
    assign judge_en  = judge_en_q;
    assign unlock    = unlock_q;
    assign lockout   = lockout_q;
    assign err_cnt   = err_cnt_q;
    assign digit_cnt = digit_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed bench for lock_entry_sequencer: pair packing, compare/unlock, failure and lockout,
// timeout, input priority and asynchronous clear.
module tb_lock_entry_sequencer;

    logic       true_clk = 1'b0;
    logic       clr = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_cancel = 1'b0;
    logic       match_in = 1'b0;
    logic       pair_wr;
    logic [1:0] pair_sel;
    logic [7:0] pair_data;
    logic       entry_clr;
    logic       judge_en;
    logic       unlock;
    logic       lockout;
    logic [1:0] err_cnt;
    logic [2:0] digit_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    lock_entry_sequencer dut (
        .true_clk  (true_clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .key_enter (key_enter),
        .key_cancel(key_cancel),
        .match_in  (match_in),
        .pair_wr   (pair_wr),
        .pair_sel  (pair_sel),
        .pair_data (pair_data),
        .entry_clr (entry_clr),
        .judge_en  (judge_en),
        .unlock    (unlock),
        .lockout   (lockout),
        .err_cnt   (err_cnt),
        .digit_cnt (digit_cnt),
        .busy      (busy)
    );

    always #5 true_clk = ~true_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of key strobes; returns at the sample point of the following cycle.
    task automatic strobe(input logic v, input logic e, input logic c, input logic [3:0] d);
        key_valid  = v;
        key_enter  = e;
        key_cancel = c;
        key_digit  = d;
        @(negedge true_clk);
        key_valid  = 1'b0;
        key_enter  = 1'b0;
        key_cancel = 1'b0;
        key_digit  = 4'd0;
    endtask

    task automatic press(input logic [3:0] d);
        strobe(1'b1, 1'b0, 1'b0, d);
    endtask

    // Counts consecutive cycles, starting with the current one, that unlock (sel=0) or lockout is high.
    task automatic count_high(input int sel, input int limit, output int n);
        n = 0;
        while (((sel == 0) ? unlock : lockout) && (n < limit)) begin
            n++;
            @(negedge true_clk);
        end
    endtask

    task automatic six_keys();
        for (int i = 1; i <= 6; i++) press(4'(i));
    endtask

    logic [7:0] exp_pair [3] = '{8'h12, 8'h34, 8'h56};
    int         n;

    initial begin
        @(negedge true_clk);
        check("reset_outputs", 32'({pair_wr, pair_sel, pair_data, entry_clr, judge_en, unlock,
                                    lockout, err_cnt, digit_cnt, busy}), 32'd0);
        clr = 1'b0;
        @(negedge true_clk);
        strobe(1'b0, 1'b1, 1'b1, 4'd0);
        check("idle_ignores_enter_cancel", 32'({busy, entry_clr}), 32'd0);

        // Full entry 1..6 and successful compare.
        for (int i = 1; i <= 6; i++) begin
            press(4'(i));
            check("entry_digit_cnt", 32'(digit_cnt), 32'(i));
            check("entry_pair_wr", 32'(pair_wr), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                check("entry_pair_sel", 32'(pair_sel), 32'(i / 2 - 1));
                check("entry_pair_data", 32'(pair_data), 32'(exp_pair[i/2-1]));
            end
        end
        match_in = 1'b1;
        strobe(1'b0, 1'b1, 1'b0, 4'd0);
        check("judge_en_pulse", 32'({judge_en, entry_clr, pair_wr}), 32'b100);
        @(negedge true_clk);
        check("wait_cycle", 32'({judge_en, unlock}), 32'd0);
        @(negedge true_clk);
        check("unlock_start", 32'({unlock, err_cnt}), 32'b100);
        count_high(0, 600, n);
        check("unlock_cycles", 32'(n), 32'd500);
        check("unlock_exit_clr", 32'({entry_clr, busy, unlock}), 32'b100);
        match_in = 1'b0;

        // Three failed compares lead to lockout.
        for (int k = 1; k <= 3; k++) begin
            six_keys();
            strobe(1'b0, 1'b1, 1'b0, 4'd0);
            check("fail_judge_en", 32'(judge_en), 32'd1);
            @(negedge true_clk);
            @(negedge true_clk);
            check("fail_entry_clr", 32'(entry_clr), 32'd1);
            check("fail_err_cnt", 32'(err_cnt), 32'(k));
            check("fail_lockout", 32'(lockout), 32'(k == 3));
            if (k < 3) @(negedge true_clk);
        end
        press(4'd1);
        check("lockout_key_no_wr", 32'({pair_wr, digit_cnt}), 32'd0);
        press(4'd2);
        check("lockout_key_no_wr2", 32'({pair_wr, digit_cnt}), 32'd0);
        count_high(1, 2100, n);
        check("lockout_cycles", 32'(n + 2), 32'd2000);
        check("lockout_exit", 32'({err_cnt, busy, lockout}), 32'd0);

        // Short entry counts as a failure without a compare.
        press(4'd1);
        press(4'd2);
        press(4'd3);
        strobe(1'b0, 1'b1, 1'b0, 4'd0);
        check("short_enter", 32'({judge_en, entry_clr, err_cnt, digit_cnt, busy}),
              32'({1'b0, 1'b1, 2'd1, 3'd0, 1'b0}));
        @(negedge true_clk);
        check("short_enter_no_judge", 32'(judge_en), 32'd0);

        // Timeout after 1000 idle cycles.
        press(4'd7);
        press(4'd8);
        check("timeout_pair", 32'({pair_wr, pair_data}), 32'h178);
        repeat (999) @(negedge true_clk);
        check("timeout_before", 32'({entry_clr, busy}), 32'b01);
        @(negedge true_clk);
        check("timeout_fire", 32'({entry_clr, busy, digit_cnt, err_cnt}),
              32'({1'b1, 1'b0, 3'd0, 2'd1}));

        // Ignored digit, then cancel beats enter and a digit in the same cycle.
        press(4'd5);
        press(4'hA);
        check("digit_above_9", 32'({digit_cnt, pair_wr}), 32'({3'd1, 1'b0}));
        strobe(1'b1, 1'b1, 1'b1, 4'd4);
        check("cancel_priority", 32'({entry_clr, pair_wr, judge_en, digit_cnt, busy, err_cnt}),
              32'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1}));

        // Asynchronous clear during unlock.
        match_in = 1'b1;
        six_keys();
        strobe(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (5) @(negedge true_clk);
        check("unlock_before_clr", 32'(unlock), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async", 32'({pair_wr, pair_sel, pair_data, entry_clr, judge_en, unlock,
                                lockout, err_cnt, digit_cnt, busy}), 32'd0);
        @(negedge true_clk);
        clr = 1'b0;
        match_in = 1'b0;
        press(4'd9);
        check("fresh_entry", 32'({digit_cnt, busy, unlock}), 32'({3'd1, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lock_entry_sequencer.md
# lock_entry_sequencer

Sequencer that replaces manual select-line stepping on the six-digit lock's code-entry datapath. It collects keypad digits on `true_clk`, packs them into digit pairs, and writes each pair into the entered-code register. On enter it triggers the compare, then runs the unlock-hold, error-count and lockout timing. It sits between the keypad front end and the existing entry register and compare logic.

## Interface
- `JUDGE_LAT`, 1: cycles from the `judge_en` pulse to valid `match_in` (1..7).
- `TIMEOUT_CYC`, 1000: idle cycles in ENTRY before the entry is abandoned.
- `UNLOCK_CYC`, 500: cycles `unlock` is held high.
- `LOCKOUT_CYC`, 2000: cycles `lockout` is held high.
- `MAX_ERR`, 3: consecutive failures that trigger lockout (1..3).

Ports (name, direction, width, meaning):
- `true_clk` in 1: system clock.
- `clr` in 1: reset, asynchronous, active-high.
- `key_valid` in 1: one-cycle strobe; `key_digit` is valid.
- `key_digit` in 4: BCD digit. Values above 9 are ignored.
- `key_enter` in 1: one-cycle strobe; submit the entry.
- `key_cancel` in 1: one-cycle strobe; abandon the entry.
- `match_in` in 1: compare result from the datapath.
- `pair_wr` out 1: one-cycle write strobe for a digit pair.
- `pair_sel` out 2: pair index (0 = high pair, 1 = middle pair, 2 = low pair).
- `pair_data` out 8: {first digit, second digit}.
- `entry_clr` out 1: one-cycle clear of the entry register.
- `judge_en` out 1: one-cycle compare trigger.
- `unlock` out 1: lock released.
- `lockout` out 1: lockout active. Drives the LED flasher enable.
- `err_cnt` out 2: consecutive failure count.
- `digit_cnt` out 3: digits accepted in the current entry (0..6).
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset puts the FSM in IDLE and clears all counters and the pending-digit register.
- Input priority within a cycle: `key_cancel` > `key_enter` > `key_valid`.
- FSM states: IDLE, ENTRY, JUDGE, WAIT, UNLOCKED, LOCKOUT.
- **IDLE**: a valid digit stores the pending digit, sets `digit_cnt`=1 and moves to ENTRY. `key_enter` and `key_cancel` are ignored.
- **ENTRY**:
  - Odd-numbered digit (1st, 3rd, 5th): held as the pending digit.
  - Even-numbered digit: `pair_wr`=1, `pair_data`={pending, new}, `pair_sel`=(`digit_cnt`/2).
  - Digits arriving when `digit_cnt`=6 are ignored.
  - Each accepted digit restarts the timeout counter.
- **ENTRY, `key_cancel` or timeout**: `entry_clr` pulse, `digit_cnt`←0, go to IDLE. `err_cnt` is unchanged.
- **ENTRY, `key_enter` with `digit_cnt`=6**: go to JUDGE.
- **ENTRY, `key_enter` with `digit_cnt`<6**: counts as a failure with no `judge_en`. Apply the failure path below.
- **JUDGE**: `judge_en` pulses for one cycle, then go to WAIT.
- **WAIT**: counts `JUDGE_LAT` cycles, then samples `match_in`.
  - `match_in`=1: `err_cnt`←0, go to UNLOCKED.
  - `match_in`=0: apply the failure path.
- **Failure path**: `err_cnt`←`err_cnt`+1, saturating at 3. Pulse `entry_clr` and set `digit_cnt`←0. If the new count ≥ `MAX_ERR`, go to LOCKOUT; otherwise go to IDLE.
- **UNLOCKED**: `unlock`=1 for `UNLOCK_CYC` cycles. On exit, pulse `entry_clr` and go to IDLE.
- **LOCKOUT**: `lockout`=1 for `LOCKOUT_CYC` cycles. On exit, `err_cnt`←0 and go to IDLE.
- In JUDGE, WAIT, UNLOCKED and LOCKOUT, all key inputs are ignored.
- Counter widths are $clog2 of the largest parameter. Timers count down to 0 with no wrap.

## Timing
- `key_valid` in cycle n:
  - `digit_cnt` updates at edge n+1.
  - For an even-numbered digit, `pair_wr` is high during cycle n+1.
- `key_enter` with 6 digits in cycle n:
  - `judge_en` high in cycle n+1.
  - `match_in` sampled at the edge ending cycle n+1+`JUDGE_LAT`.
  - `unlock` or `entry_clr` is visible in the following cycle.
- `unlock` stays high for exactly `UNLOCK_CYC` cycles.
- `lockout` stays high for exactly `LOCKOUT_CYC` cycles.
- Timeout fires when the idle-cycle count reaches `TIMEOUT_CYC`. `entry_clr` is high in the next cycle.
- `pair_wr`, `entry_clr` and `judge_en` are never asserted together.
- `clr` asserted mid-operation forces all outputs to 0 asynchronously, including an unlock or lockout in progress.

## Test plan
- Keys 1,2,3,4,5,6 → `pair_wr` three times with (`pair_sel`, `pair_data`) = (0, 0x12), (1, 0x34), (2, 0x56); `digit_cnt` ends at 6. Then enter with `match_in`=1 → `judge_en` one cycle later, `unlock` high for 500 cycles, `err_cnt`=0.
- Three full entries each answered with `match_in`=0 → `err_cnt` reads 1, 2, then 3. After the third failure `lockout` is high for 2000 cycles; keys during lockout produce no `pair_wr`. `err_cnt`=0 afterwards.
- Keys 7,8 then idle for 1000 cycles → `entry_clr` pulses, state returns to IDLE (`busy`=0), `err_cnt` unchanged.
- Keys 1,2,3 then `key_enter` → no `judge_en`, `err_cnt`+1, `entry_clr` pulses.
- `key_cancel`, `key_enter` and `key_valid` (digit 4) in the same cycle during ENTRY → cancel wins: `entry_clr` pulses, no `pair_wr`. Separately, `key_digit`=0xA → ignored, `digit_cnt` unchanged.
- `clr` pulsed mid-UNLOCKED → `unlock`=0 immediately, all outputs 0. The next key starts a fresh entry with `digit_cnt`=1.
